sevenseg_capture: RTL and testbench



---
 rtl/sevenseg_pkg.sv | 27 ++
 rtl/sevenseg_pattern_decode.sv | 42 ++++
 rtl/sevenseg_capture.sv | 179 +++++++++++++++++
 tb/tb_sevenseg_capture.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
//------------------------------------------------------------------------------
// Module   : sevenseg_pkg
// Brief    : Shared seven-segment pattern table and types (active-low a..g).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sevenseg_pkg;

    typedef logic [1:7] seg_t;
    typedef logic [3:0] bcd_t;

    localparam seg_t SEG_0     = 7'b0000001;
    localparam seg_t SEG_1     = 7'b1001111;
    localparam seg_t SEG_2     = 7'b0010010;
    localparam seg_t SEG_3     = 7'b0000110;
    localparam seg_t SEG_4     = 7'b1001100;
    localparam seg_t SEG_5     = 7'b0100100;
    localparam seg_t SEG_6     = 7'b0100000;
    localparam seg_t SEG_7     = 7'b0001111;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0000100;
    localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

`default_nettype wire

// File: rtl/sevenseg_pattern_decode.sv
//------------------------------------------------------------------------------
// Module   : sevenseg_pattern_decode
// Brief    : Combinational seven-segment pattern to BCD lookup.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sevenseg_pattern_decode
    import sevenseg_pkg::*;
(
    input  seg_t i_seg,
    output bcd_t o_value,
    output logic o_is_digit,
    output logic o_is_blank
);

    always_comb begin
        o_value    = 4'd0;
        o_is_digit = 1'b1;
        o_is_blank = 1'b0;
        case (i_seg)
            SEG_0:     o_value = 4'd0;
            SEG_1:     o_value = 4'd1;
            SEG_2:     o_value = 4'd2;
            SEG_3:     o_value = 4'd3;
            SEG_4:     o_value = 4'd4;
            SEG_5:     o_value = 4'd5;
            SEG_6:     o_value = 4'd6;
            SEG_7:     o_value = 4'd7;
            SEG_8:     o_value = 4'd8;
            SEG_9:     o_value = 4'd9;
            SEG_BLANK: begin
                o_is_digit = 1'b0;
                o_is_blank = 1'b1;
            end
            default:   o_is_digit = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/sevenseg_capture.sv
//------------------------------------------------------------------------------
// Module   : sevenseg_capture
// Brief    : Recovers BCD digits from a multiplexed active-low 7-seg bus.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:7]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   pattern_err,
    output logic                    update
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int AGE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_count = 2'd1;
    localparam logic [1:0] c_st_held  = 2'd2;

    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_stable = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_last   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [AGE_W-1:0] c_age_max    = AGE_W'(TIMEOUT_CYCLES);
    localparam logic [AGE_W-1:0] c_age_last   = AGE_W'(TIMEOUT_CYCLES - 1);
    localparam bit               c_age_en     = (TIMEOUT_CYCLES > 0);

    logic [NUM_DIGITS-1:0] r_sel;
    seg_t                  r_seg;
    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_update;

    logic [1:0]            w_state_next;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  w_commit;
    logic                  w_same;
    logic                  w_onehot;
    logic [3:0]            w_zeros;

    bcd_t                  w_dec_value;
    logic                  w_dec_is_digit;
    logic                  w_dec_is_blank;

    // The incoming pair is judged against the pair registered on the previous edge.
    assign w_same = ({dig_sel, seg_in} == {r_sel, r_seg});

    always_comb begin
        w_zeros = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_zeros = w_zeros + {3'b000, ~dig_sel[i]};
        end
        w_onehot = (w_zeros == 4'd1);
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_commit     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_onehot) begin
                    w_state_next = c_st_count;
                    w_cnt_next   = c_cnt_one;
                end else begin
                    w_cnt_next   = '0;
                end
            end
            c_st_count: begin
                if (!w_onehot) begin
                    w_state_next = c_st_idle;
                    w_cnt_next   = '0;
                end else if (!w_same) begin
                    w_cnt_next   = c_cnt_one;
                end else if (r_cnt == c_cnt_last) begin
                    // Registered sample equals the incoming one, so it is safe to decode.
                    w_commit     = 1'b1;
                    w_state_next = c_st_held;
                    w_cnt_next   = c_cnt_stable;
                end else begin
                    w_cnt_next   = r_cnt + 1'b1;
                end
            end
            c_st_held: begin
                if (!w_onehot) begin
                    w_state_next = c_st_idle;
                    w_cnt_next   = '0;
                end else if (!w_same) begin
                    w_state_next = c_st_count;
                    w_cnt_next   = c_cnt_one;
                end
            end
            default: begin
                w_state_next = c_st_idle;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel    <= '0;
            r_seg    <= '0;
            r_state  <= c_st_idle;
            r_cnt    <= '0;
            r_update <= 1'b0;
        end else begin
            r_sel    <= dig_sel;
            r_seg    <= seg_in;
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_update <= w_commit;
        end
    end

    sevenseg_pattern_decode u_decode (
        .i_seg      (r_seg),
        .o_value    (w_dec_value),
        .o_is_digit (w_dec_is_digit),
        .o_is_blank (w_dec_is_blank)
    );

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        logic [3:0]       r_val;
        logic             r_ok;
        logic             r_bad;
        logic [AGE_W-1:0] r_age;
        logic             w_hit;

        assign w_hit = w_commit & ~r_sel[k];

        always_ff @(posedge clk) begin
            if (reset) begin
                r_val <= 4'd0;
                r_ok  <= 1'b0;
                r_bad <= 1'b0;
                r_age <= '0;
            end else if (w_hit) begin
                r_age <= '0;
                if (w_dec_is_digit) begin
                    r_val <= w_dec_value;
                    r_ok  <= 1'b1;
                end else begin
                    r_ok  <= 1'b0;
                    if (!w_dec_is_blank) begin
                        r_bad <= 1'b1;
                    end
                end
            end else begin
                if (r_age != c_age_max) begin
                    r_age <= r_age + 1'b1;
                end
                if (c_age_en && (r_age == c_age_last)) begin
                    r_ok <= 1'b0;
                end
            end
        end

        assign digits[4*k +: 4] = r_val;
        assign digit_valid[k]   = r_ok;
        assign pattern_err[k]   = r_bad;
    end

    assign update = r_update;

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_capture.sv
//------------------------------------------------------------------------------
// Module   : tb_sevenseg_capture
// Brief    : Self-checking bench for sevenseg_capture with a run-length model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sevenseg_capture;

    localparam int ND  = 4;
    localparam int STB = 4;
    localparam int TO  = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:7]    seg_in = 7'h7F;
    logic [ND-1:0] dig_sel = 4'hF;
    logic [4*ND-1:0] digits;
    logic [ND-1:0] digit_valid;
    logic [ND-1:0] pattern_err;
    logic          update;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sevenseg_capture #(
        .NUM_DIGITS     (ND),
        .STABLE_CYCLES  (STB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .digits      (digits),
        .digit_valid (digit_valid),
        .pattern_err (pattern_err),
        .update      (update)
    );

    // Reference model: run length of identical one-hot samples and cycles since commit.
    logic [6:0] tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    int          run = 0;
    logic [10:0] prev = '0;
    int          since [ND];
    logic [15:0] m_digits = '0;
    logic [3:0]  m_valid = '0;
    logic [3:0]  m_err = '0;
    logic        m_update = 1'b0;

    task automatic model_edge(input logic [3:0] s, input logic [6:0] g);
        bit oh;
        bit commit;
        int hit;
        if (reset) begin
            run = 0; prev = '0; m_digits = '0; m_valid = '0; m_err = '0; m_update = 1'b0;
            for (int d = 0; d < ND; d++) since[d] = 0;
        end else begin
            oh = ($countones(~s) == 1);
            if (oh && ({s, g} == prev)) run++;
            else run = oh ? 1 : 0;
            prev = {s, g};
            commit = oh && (run == STB);
            m_update = commit;
            for (int d = 0; d < ND; d++) begin
                if (commit && !s[d]) begin
                    since[d] = 0;
                    hit = -1;
                    for (int v = 0; v < 10; v++) if (tbl[v] == g) hit = v;
                    if (hit >= 0) begin
                        m_digits[4*d +: 4] = 4'(hit);
                        m_valid[d] = 1'b1;
                    end else begin
                        m_valid[d] = 1'b0;
                        if (g != 7'h7F) m_err[d] = 1'b1;
                    end
                end else begin
                    if (since[d] < TO) since[d]++;
                    if (since[d] == TO) m_valid[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic tick(input logic [3:0] s, input logic [6:0] g);
        dig_sel = s;
        seg_in  = g;
        @(posedge clk);
        model_edge(s, g);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(4'hF, 7'h7F);
        tick(4'hF, 7'h7F);
        reset = 1'b0;
        checks++;
        if ({digits, digit_valid, pattern_err, update} !== 25'd0) begin
            failures++;
            $display("FAIL reset_state: got %h/%b/%b/%b want 0/0/0/0", digits, digit_valid, pattern_err, update);
        end
    endtask

    task automatic test_single_commit();
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            tick(4'b1110, 7'b0010010);
            n += int'(update);
        end
        checks++;
        if (n != 1 || update !== 1'b1) begin
            failures++;
            $display("FAIL single_update: pulses %0d last %b want 1 on edge 4", n, update);
        end
        checks++;
        if (digits !== 16'h0002 || digit_valid !== 4'b0001 || pattern_err !== 4'b0000) begin
            failures++;
            $display("FAIL single_value: got %h/%b/%b want 0002/0001/0000", digits, digit_valid, pattern_err);
        end
    endtask

    task automatic test_short_hold();
        int n = 0;
        tick(4'hF, 7'h7F);
        checks++;
        if (update !== 1'b0) begin
            failures++;
            $display("FAIL pulse_width: update %b want 0", update);
        end
        for (int i = 0; i < 3; i++) begin
            tick(4'b1110, 7'b0010010);
            n += int'(update);
        end
        for (int i = 0; i < 4; i++) begin
            tick(4'b1110, 7'b0000110);
            n += int'(update);
        end
        checks++;
        if (n != 1 || digits[3:0] !== 4'd3) begin
            failures++;
            $display("FAIL short_hold: pulses %0d digit0 %0d want 1 and 3", n, digits[3:0]);
        end
    endtask

    task automatic test_scan();
        int vals [4] = '{1, 9, 6, 7};
        int n = 0;
        logic [3:0] s;
        for (int d = 0; d < 4; d++) begin
            s = 4'hF ^ (4'd1 << d);
            for (int e = 1; e <= 6; e++) begin
                tick(s, tbl[vals[d]]);
                n += int'(update);
                if (e >= 5) begin
                    checks++;
                    if (update !== 1'b0) begin
                        failures++;
                        $display("FAIL scan_hold_pulse: digit %0d edge %0d update %b want 0", d, e, update);
                    end
                end
                if (d == 3 && e == 4) begin
                    checks++;
                    if (digits !== 16'h7691 || digit_valid !== 4'b1111) begin
                        failures++;
                        $display("FAIL scan_value: got %h/%b want 7691/1111", digits, digit_valid);
                    end
                end
            end
        end
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL scan_pulses: got %0d want 4", n);
        end
    endtask

    task automatic test_multi_low();
        int n = 0;
        logic [15:0] saved = digits;
        for (int i = 0; i < 10; i++) begin
            tick(4'b1100, 7'b0010010);
            n += int'(update);
        end
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL multi_low: pulses %0d want 0", n);
        end
        for (int i = 0; i < 4; i++) tick(4'b1101, 7'b1111110);
        checks++;
        if (pattern_err !== 4'b0010 || digit_valid[1] !== 1'b0 || digits !== saved || update !== 1'b1) begin
            failures++;
            $display("FAIL illegal_pattern: err %b valid1 %b digits %h upd %b want 0010/0/%h/1",
                     pattern_err, digit_valid[1], digits, update, saved);
        end
    endtask

    task automatic test_timeout();
        int j = 0;
        for (int i = 0; i < 4; i++) tick(4'b1011, 7'b0100100);
        checks++;
        if (digit_valid[2] !== 1'b1 || digits[11:8] !== 4'd5) begin
            failures++;
            $display("FAIL timeout_commit: valid2 %b digit2 %0d want 1 and 5", digit_valid[2], digits[11:8]);
        end
        while (digit_valid[2] === 1'b1 && j < 40) begin
            tick(4'hF, 7'h7F);
            j++;
        end
        checks++;
        if (j != TO || digits[11:8] !== 4'd5) begin
            failures++;
            $display("FAIL timeout_age: dropped after %0d cycles digit2 %0d want %0d and 5", j, digits[11:8], TO);
        end
    endtask

    task automatic test_reset_midcount();
        tick(4'hF, 7'h7F);
        tick(4'b0111, 7'b0000000);
        tick(4'b0111, 7'b0000000);
        reset = 1'b1;
        tick(4'b0111, 7'b0000000);
        reset = 1'b0;
        checks++;
        if ({digits, digit_valid, pattern_err, update} !== 25'd0) begin
            failures++;
            $display("FAIL reset_mid: got %h/%b/%b/%b want 0/0/0/0", digits, digit_valid, pattern_err, update);
        end
        for (int i = 1; i <= 4; i++) begin
            tick(4'b0111, 7'b0000000);
            checks++;
            if (update !== (i == 4)) begin
                failures++;
                $display("FAIL reset_restart: edge %0d update %b want %b", i, update, i == 4);
            end
        end
        checks++;
        if (digits[15:12] !== 4'd8) begin
            failures++;
            $display("FAIL reset_restart_value: digit3 %0d want 8", digits[15:12]);
        end
    endtask

    task automatic test_random();
        logic [3:0] s;
        logic [6:0] g;
        int hold;
        int r;
        for (int b = 0; b < 250; b++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70) s = 4'hF ^ (4'd1 << $urandom_range(0, 3));
            else s = 4'($urandom);
            r = int'($urandom_range(0, 99));
            if (r < 60) g = tbl[$urandom_range(0, 9)];
            else if (r < 75) g = 7'h7F;
            else g = 7'($urandom);
            hold = int'($urandom_range(1, 7));
            reset = ($urandom_range(0, 99) < 3);
            for (int h = 0; h < hold; h++) begin
                tick(s, g);
                reset = 1'b0;
                checks++;
                if ({digits, digit_valid, pattern_err, update} !== {m_digits, m_valid, m_err, m_update}) begin
                    failures++;
                    $display("FAIL random_model: burst %0d got %h/%b/%b/%b want %h/%b/%b/%b", b,
                             digits, digit_valid, pattern_err, update, m_digits, m_valid, m_err, m_update);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < ND; d++) since[d] = 0;
        test_reset();
        test_single_commit();
        test_short_hold();
        test_scan();
        test_multi_low();
        test_timeout();
        test_reset_midcount();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
